// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT output serializer.
// FFT_SER_FFTSHIFT_EN selects zero-frequency-centred emission order.
package fft_pkg;

   localparam int NUM_BINS = 8;
   localparam int BIN_W    = 3;
   localparam int CPLX_W   = 16;

   // Complex sample at the default component width; the RTL carries {real, imag} in this packing.
   typedef struct packed {
      logic signed [CPLX_W-1:0] re;
      logic signed [CPLX_W-1:0] im;
   } cplx_t;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_t;

   function automatic logic [BIN_W-1:0] order(input logic [BIN_W-1:0] bin);
`ifdef FFT_SER_FFTSHIFT_EN
      return bin ^ 3'd4;
`else
      return bin;
`endif
   endfunction

endpackage

// File: rtl/fft_output_serializer_if.sv
// Frame-capture and sample-stream signals of the FFT output serializer.
interface fft_output_serializer_if #(parameter int WIDTH = 16);

   // Handshakes: a frame is taken on the edge where s_valid && s_ready; a sample is
   // taken on the edge where m_valid && m_ready, and while m_valid && !m_ready the
   // m_* outputs hold. s_ready and m_valid depend only on registered occupancy.
   logic                    s_valid;
   logic                    s_ready;
   logic signed [WIDTH-1:0] x_in_0_real, x_in_0_imag;
   logic signed [WIDTH-1:0] x_in_1_real, x_in_1_imag;
   logic signed [WIDTH-1:0] x_in_2_real, x_in_2_imag;
   logic signed [WIDTH-1:0] x_in_3_real, x_in_3_imag;
   logic signed [WIDTH-1:0] x_in_4_real, x_in_4_imag;
   logic signed [WIDTH-1:0] x_in_5_real, x_in_5_imag;
   logic signed [WIDTH-1:0] x_in_6_real, x_in_6_imag;
   logic signed [WIDTH-1:0] x_in_7_real, x_in_7_imag;
   logic                    m_valid;
   logic                    m_ready;
   logic signed [WIDTH-1:0] m_real;
   logic signed [WIDTH-1:0] m_imag;
   logic [2:0]              m_index;
   logic                    m_last;
   logic                    overflow;

   modport slave (
      input  s_valid,
      input  x_in_0_real, x_in_0_imag, x_in_1_real, x_in_1_imag,
      input  x_in_2_real, x_in_2_imag, x_in_3_real, x_in_3_imag,
      input  x_in_4_real, x_in_4_imag, x_in_5_real, x_in_5_imag,
      input  x_in_6_real, x_in_6_imag, x_in_7_real, x_in_7_imag,
      input  m_ready,
      output s_ready, m_valid, m_real, m_imag, m_index, m_last, overflow
   );

   modport master (
      output s_valid,
      output x_in_0_real, x_in_0_imag, x_in_1_real, x_in_1_imag,
      output x_in_2_real, x_in_2_imag, x_in_3_real, x_in_3_imag,
      output x_in_4_real, x_in_4_imag, x_in_5_real, x_in_5_imag,
      output x_in_6_real, x_in_6_imag, x_in_7_real, x_in_7_imag,
      output m_ready,
      input  s_ready, m_valid, m_real, m_imag, m_index, m_last, overflow
   );

endinterface

// File: rtl/fft_frame_buffer.sv
// Ping-pong frame store: whole-frame write into one slot, single-entry read.
module fft_frame_buffer
   import fft_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int NUM_FRAMES = 2
) (
   input  logic                                 clk,
   input  logic                                 wr_en,
   input  logic                                 wr_slot,
   input  logic [NUM_BINS-1:0][2*WIDTH-1:0]     wr_data,
   input  logic                                 rd_slot,
   input  logic [BIN_W-1:0]                     rd_idx,
   output logic [2*WIDTH-1:0]                   rd_data
);

   // Contents are left unreset; a slot is only read after a full frame lands in it.
   logic [2*WIDTH-1:0] mem_q [NUM_FRAMES][NUM_BINS];
   logic [2*WIDTH-1:0] mem_d [NUM_FRAMES][NUM_BINS];

   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         for (int k = 0; k < NUM_BINS; k++) begin
            mem_d[wr_slot][k] = wr_data[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rd_data = mem_q[rd_slot][rd_idx];

endmodule

// File: rtl/fft_output_serializer.sv
// Captures 8-bin FFT frames into a two-slot buffer and streams them one bin per cycle.
// Define FFT_SER_FFTSHIFT_EN to emit bins in 4..7,0..3 order.
module fft_output_serializer
   import fft_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int NUM_FRAMES = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   fft_output_serializer_if.slave  bus,
   output occ_t                    dbg_occ
);

   occ_t             state_q, state_d;
   logic             wr_sel_q, wr_sel_d;
   logic             rd_sel_q, rd_sel_d;
   logic [BIN_W-1:0] bin_q, bin_d;
   logic             overflow_q, overflow_d;

   logic             s_ready;
   logic             m_valid;
   logic             capture;
   logic             xfer;
   logic             pop_last;
   logic [BIN_W-1:0] rd_idx;
   logic [2*WIDTH-1:0] rd_data;
   logic [NUM_BINS-1:0][2*WIDTH-1:0] wr_data;

   assign s_ready  = (state_q != OCC_FULL);
   assign m_valid  = (state_q != OCC_EMPTY);
   assign capture  = bus.s_valid && s_ready;
   assign xfer     = m_valid && bus.m_ready;
   assign pop_last = xfer && (bin_q == 3'd7);
   assign rd_idx   = order(bin_q);

   assign wr_data[0] = {bus.x_in_0_real, bus.x_in_0_imag};
   assign wr_data[1] = {bus.x_in_1_real, bus.x_in_1_imag};
   assign wr_data[2] = {bus.x_in_2_real, bus.x_in_2_imag};
   assign wr_data[3] = {bus.x_in_3_real, bus.x_in_3_imag};
   assign wr_data[4] = {bus.x_in_4_real, bus.x_in_4_imag};
   assign wr_data[5] = {bus.x_in_5_real, bus.x_in_5_imag};
   assign wr_data[6] = {bus.x_in_6_real, bus.x_in_6_imag};
   assign wr_data[7] = {bus.x_in_7_real, bus.x_in_7_imag};

   fft_frame_buffer #(
      .WIDTH      (WIDTH),
      .NUM_FRAMES (NUM_FRAMES)
   ) u_buf (
      .clk     (clk),
      .wr_en   (capture),
      .wr_slot (wr_sel_q),
      .wr_data (wr_data),
      .rd_slot (rd_sel_q),
      .rd_idx  (rd_idx),
      .rd_data (rd_data)
   );

   // A full buffer refuses capture even when the last bin pops the same cycle.
   always_comb begin
      state_d    = state_q;
      wr_sel_d   = wr_sel_q;
      rd_sel_d   = rd_sel_q;
      bin_d      = bin_q;
      overflow_d = overflow_q;
      if (capture) wr_sel_d = ~wr_sel_q;
      if (xfer) bin_d = bin_q + 3'd1;
      if (pop_last) rd_sel_d = ~rd_sel_q;
      if (bus.s_valid && !s_ready) overflow_d = 1'b1;
      unique case (state_q)
         OCC_EMPTY: if (capture) state_d = OCC_ONE;
         OCC_ONE: begin
            if (capture && !pop_last) state_d = OCC_FULL;
            else if (!capture && pop_last) state_d = OCC_EMPTY;
         end
         OCC_FULL: if (pop_last) state_d = OCC_ONE;
         default: state_d = OCC_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= OCC_EMPTY;
         wr_sel_q   <= 1'b0;
         rd_sel_q   <= 1'b0;
         bin_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_sel_q   <= wr_sel_d;
         rd_sel_q   <= rd_sel_d;
         bin_q      <= bin_d;
         overflow_q <= overflow_d;
      end
   end

   assign bus.s_ready  = s_ready;
   assign bus.m_valid  = m_valid;
   assign bus.m_real   = m_valid ? rd_data[2*WIDTH-1:WIDTH] : '0;
   assign bus.m_imag   = m_valid ? rd_data[WIDTH-1:0] : '0;
   assign bus.m_index  = m_valid ? rd_idx : '0;
   assign bus.m_last   = m_valid && (bin_q == 3'd7);
   assign bus.overflow = overflow_q;
   assign dbg_occ      = state_q;

endmodule

// File: tb/tb_fft_output_serializer.sv
// Randomised scoreboard bench for fft_output_serializer against a frame-level reference model.
module tb_fft_output_serializer;
   import fft_pkg::*;

   localparam int W  = 16;
   localparam int SW = BIN_W + 1 + 2*W;
`ifdef FFT_SER_FFTSHIFT_EN
   localparam int ROT = 4;
`else
   localparam int ROT = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   occ_t dbg_occ;

   fft_output_serializer_if #(.WIDTH(W)) bus();

   fft_output_serializer #(.WIDTH(W), .NUM_FRAMES(2)) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .dbg_occ (dbg_occ)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [SW-1:0] exp_q[$];
   int frames_in  = 0;
   int frames_out = 0;
   bit exp_ovf    = 1'b0;
   bit pend_valid = 1'b0;
   int ready_mode = 0;
   logic [W-1:0] fr_re[NUM_BINS], fr_im[NUM_BINS];
   logic [W-1:0] pend_re[NUM_BINS], pend_im[NUM_BINS];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic apply_frame();
      bus.x_in_0_real = fr_re[0]; bus.x_in_0_imag = fr_im[0];
      bus.x_in_1_real = fr_re[1]; bus.x_in_1_imag = fr_im[1];
      bus.x_in_2_real = fr_re[2]; bus.x_in_2_imag = fr_im[2];
      bus.x_in_3_real = fr_re[3]; bus.x_in_3_imag = fr_im[3];
      bus.x_in_4_real = fr_re[4]; bus.x_in_4_imag = fr_im[4];
      bus.x_in_5_real = fr_re[5]; bus.x_in_5_imag = fr_im[5];
      bus.x_in_6_real = fr_re[6]; bus.x_in_6_imag = fr_im[6];
      bus.x_in_7_real = fr_re[7]; bus.x_in_7_imag = fr_im[7];
   endtask

   task automatic rand_frame();
      for (int k = 0; k < NUM_BINS; k++) begin
         fr_re[k] = W'($urandom);
         fr_im[k] = W'($urandom);
      end
   endtask

   task automatic ramp_frame();
      for (int k = 0; k < NUM_BINS; k++) begin
         fr_re[k] = W'(100 * k);
         fr_im[k] = W'(-k);
      end
   endtask

   // One cycle of stimulus: check occupancy-derived flags, then present a strobe or idle.
   task automatic drive_cycle(input bit sv);
      bit acc;
      @(negedge clk);
      check("s_ready", bus.s_ready, (frames_in - frames_out) != 2);
      check("overflow", bus.overflow, exp_ovf);
      check("occupancy", dbg_occ, frames_in - frames_out);
      acc = sv && ((frames_in - frames_out) != 2);
      if (sv && !acc) exp_ovf = 1'b1;
      bus.s_valid = sv;
      apply_frame();
      if (acc) begin
         pend_re    = fr_re;
         pend_im    = fr_im;
         pend_valid = 1'b1;
      end
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst         = 1'b1;
      bus.s_valid = 1'b0;
      repeat (n - 1) @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      frames_in  = 0;
      frames_out = 0;
      exp_ovf    = 1'b0;
      pend_valid = 1'b0;
      check("rst_m_valid", bus.m_valid, 0);
      check("rst_s_ready", bus.s_ready, 1);
      check("rst_overflow", bus.overflow, 0);
      check("rst_outputs", {bus.m_index, bus.m_last, bus.m_real, bus.m_imag}, 0);
   endtask

   // Reference model: an accepted frame becomes 8 samples in emission order after its capture edge.
   always @(posedge clk) begin
      #1;
      if (pend_valid) begin
         for (int j = 0; j < NUM_BINS; j++) begin
            int idx;
            logic [BIN_W-1:0] ix;
            logic lst;
            idx = (j + ROT) % NUM_BINS;
            ix  = BIN_W'(idx);
            lst = (j == NUM_BINS - 1);
            exp_q.push_back({ix, lst, pend_re[idx], pend_im[idx]});
         end
         frames_in++;
         pend_valid = 1'b0;
      end
   end

   initial begin
      bus.m_ready = 1'b1;
      forever begin
         @(negedge clk);
         case (ready_mode)
            0:       bus.m_ready = 1'b1;
            1:       bus.m_ready = 1'b0;
            2:       bus.m_ready = ~bus.m_ready;
            default: bus.m_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: compares each presented sample against the head of the expected queue.
   initial begin
      logic [SW-1:0] got;
      logic [SW-1:0] prev;
      bit prev_stall;
      prev_stall = 1'b0;
      prev       = '0;
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            check("m_valid", bus.m_valid, exp_q.size() != 0);
            got = {bus.m_index, bus.m_last, bus.m_real, bus.m_imag};
            if (bus.m_valid && exp_q.size() != 0) begin
               check("sample", got, exp_q[0]);
               if (prev_stall) check("stall_hold", got, prev);
               if (bus.m_ready) begin
                  if (exp_q[0][2*W]) frames_out++;
                  void'(exp_q.pop_front());
               end
               prev_stall = !bus.m_ready;
               prev       = got;
            end else if (!bus.m_valid) begin
               check("idle_zero", got, 0);
               prev_stall = 1'b0;
            end
         end
      end
   end

   initial begin
      bus.s_valid = 1'b0;
      for (int k = 0; k < NUM_BINS; k++) begin
         fr_re[k] = '0;
         fr_im[k] = '0;
      end
      apply_frame();
      do_reset(2);

      ready_mode = 0;
      ramp_frame();
      drive_cycle(1'b1);
      rand_frame();
      repeat (12) drive_cycle(1'b0);

      rand_frame(); drive_cycle(1'b1);
      rand_frame(); drive_cycle(1'b1);
      repeat (20) drive_cycle(1'b0);

      ready_mode = 1;
      repeat (3) begin
         rand_frame();
         drive_cycle(1'b1);
      end
      repeat (3) drive_cycle(1'b0);
      check("overflow_sticky", bus.overflow, 1);
      ready_mode = 0;
      repeat (24) drive_cycle(1'b0);

      ready_mode = 2;
      rand_frame(); drive_cycle(1'b1);
      rand_frame(); drive_cycle(1'b1);
      repeat (40) drive_cycle(1'b0);

      ready_mode = 0;
      repeat (2) drive_cycle(1'b0);
      ramp_frame();
      drive_cycle(1'b1);
      repeat (3) drive_cycle(1'b0);
      do_reset(1);
      rand_frame(); drive_cycle(1'b1);
      repeat (12) drive_cycle(1'b0);

      ready_mode = 3;
      repeat (300) begin
         rand_frame();
         drive_cycle($urandom_range(0, 3) == 0);
      end
      ready_mode = 0;
      repeat (40) drive_cycle(1'b0);
      check("drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
